// File: rtl/fetch_sequencer_if.sv
// Instruction-memory and datapath-issue bus between the fetch sequencer
// (master) and the program memory / datapath (slave).
interface fetch_sequencer_if #(
  parameter int ADDR_W  = 4,
  parameter int INSTR_W = 20
);
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_instr;
  logic               exec_valid;
  logic               exec_ready;
  logic [3:0]         exec_opcode;
  logic [7:0]         exec_op1;
  logic [7:0]         exec_op2;
  logic               exec_done;

  modport master (
    output imem_addr, exec_valid, exec_opcode, exec_op1, exec_op2,
    input  imem_instr, exec_ready, exec_done
  );

  modport slave (
    input  imem_addr, exec_valid, exec_opcode, exec_op1, exec_op2,
    output imem_instr, exec_ready, exec_done
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction fetch/issue controller. Owns the program counter, latches each
// instruction, executes JMP/HALT locally and hands every other instruction to
// the datapath with a valid/ready handshake followed by a done pulse.
module fetch_sequencer #(
  parameter int         ADDR_W  = 4,
  parameter int         INSTR_W = 20,
  parameter logic [3:0] JMP_OP  = 4'b1110,
  parameter logic [3:0] HALT_OP = 4'b1111
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  fetch_sequencer_if.master    bus,
  output logic [ADDR_W-1:0]    pc,
  output logic                 halted,
  output logic [7:0]           retired
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_ISSUE  = 3'd3,
    ST_WAIT   = 3'd4,
    ST_HALTED = 3'd5
  } state_t;

  state_t             state_r, state_nx_s;
  logic [ADDR_W-1:0]  pc_r, pc_nx_s;
  logic [INSTR_W-1:0] ir_r, ir_nx_s;
  logic [7:0]         retired_r, retired_nx_s;
  logic               exec_valid_r;
  logic               halted_r;
  logic [3:0]         opcode_s;

  // Retired counter increment that sticks at its maximum instead of wrapping.
  function automatic logic [7:0] sat_inc(input logic [7:0] value);
    if (value == 8'hFF) begin
      return 8'hFF;
    end else begin
      return value + 8'd1;
    end
  endfunction

  assign opcode_s = ir_r[INSTR_W-1 -: 4];

  // Next-state, program counter, instruction register and retire-count logic.
  always_comb begin
    state_nx_s   = state_r;
    pc_nx_s      = pc_r;
    ir_nx_s      = ir_r;
    retired_nx_s = retired_r;
    case (state_r)
      ST_IDLE: begin
        pc_nx_s = {ADDR_W{1'b0}};
        if (start) begin
          state_nx_s = ST_FETCH;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_FETCH: begin
        ir_nx_s    = bus.imem_instr;
        state_nx_s = ST_DECODE;
      end
      ST_DECODE: begin
        if (opcode_s == HALT_OP) begin
          state_nx_s = ST_HALTED;
        end else if (opcode_s == JMP_OP) begin
          // Target comes from the low bits of op1; the rest is ignored.
          pc_nx_s      = ir_r[8 +: ADDR_W];
          retired_nx_s = sat_inc(retired_r);
          state_nx_s   = ST_FETCH;
        end else begin
          state_nx_s = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (bus.exec_ready) begin
          state_nx_s = ST_WAIT;
        end else begin
          state_nx_s = ST_ISSUE;
        end
      end
      ST_WAIT: begin
        if (bus.exec_done) begin
          pc_nx_s      = pc_r + {{(ADDR_W-1){1'b0}}, 1'b1};
          retired_nx_s = sat_inc(retired_r);
          state_nx_s   = ST_FETCH;
        end else begin
          state_nx_s = ST_WAIT;
        end
      end
      ST_HALTED: begin
        if (start) begin
          pc_nx_s    = {ADDR_W{1'b0}};
          state_nx_s = ST_FETCH;
        end else begin
          state_nx_s = ST_HALTED;
        end
      end
      default: begin
        pc_nx_s    = {ADDR_W{1'b0}};
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Datapath registers; valid/halted are registered decodes of the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_r         <= {ADDR_W{1'b0}};
      ir_r         <= {INSTR_W{1'b0}};
      retired_r    <= 8'd0;
      exec_valid_r <= 1'b0;
      halted_r     <= 1'b0;
    end else begin
      pc_r         <= pc_nx_s;
      ir_r         <= ir_nx_s;
      retired_r    <= retired_nx_s;
      exec_valid_r <= (state_nx_s == ST_ISSUE);
      halted_r     <= (state_nx_s == ST_HALTED);
    end
  end

  assign bus.imem_addr   = pc_r;
  assign bus.exec_valid  = exec_valid_r;
  assign bus.exec_opcode = opcode_s;
  assign bus.exec_op1    = ir_r[15:8];
  assign bus.exec_op2    = ir_r[7:0];
  assign pc              = pc_r;
  assign halted          = halted_r;
  assign retired         = retired_r;

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Instruction fetch/issue controller for the 8-bit processor. It owns the program counter and drives the address of the 16-entry combinational program memory. It latches each 20-bit instruction {opcode[19:16], op1[15:8], op2[7:0]}, decodes the control-flow opcodes itself (JMP, HALT), and issues every other instruction to the datapath over a valid/ready plus done handshake.

Parameters:
ADDR_W, 4, program counter / instruction memory address width (16 entries)
INSTR_W, 20, instruction width: 4-bit opcode, 8-bit op1, 8-bit op2
JMP_OP, 4'b1110, opcode handled internally: pc <= op1[ADDR_W-1:0]
HALT_OP, 4'b1111, opcode handled internally: stop sequencing

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  level; begin or restart execution from address 0 when IDLE or HALTED
imem_addr  out  ADDR_W  address to program memory; equals pc
imem_instr  in  INSTR_W  instruction from program memory, combinational on imem_addr
exec_valid  out  1  issued instruction fields are valid
exec_ready  in  1  datapath accepts issued instruction
exec_opcode  out  4  issued opcode (registered IR[19:16])
exec_op1  out  8  issued operand 1 (IR[15:8])
exec_op2  out  8  issued operand 2 (IR[7:0])
exec_done  in  1  single-cycle pulse; datapath finished accepted instruction
pc  out  ADDR_W  current program counter
halted  out  1  high in HALTED state
retired  out  8  count of retired instructions, saturating at 255

Behaviour:
- Reset (async, rst_n=0): state=IDLE; pc=0; IR=0; exec_valid=0; halted=0; retired=0. exec_opcode/op1/op2 read 0.
- States: IDLE, FETCH, DECODE, ISSUE, WAIT, HALTED. Each transition is one clock.
- IDLE: pc held at 0. start=1 -> FETCH.
- FETCH: IR <= imem_instr (memory addressed by the current pc) -> DECODE.
- DECODE:
  - IR opcode == HALT_OP -> HALTED; pc unchanged; HALT not counted in retired.
  - IR opcode == JMP_OP -> pc <= IR[ADDR_W-1:0] of op1 (upper op1 bits ignored); retired += 1; -> FETCH.
  - Any other opcode -> ISSUE.
- ISSUE: exec_valid=1. Opcode/op1/op2 are stable from IR while exec_valid=1. When exec_ready=1 is sampled -> WAIT, and exec_valid is 0 from the next cycle. Waits indefinitely otherwise.
- WAIT: exec_valid=0. On exec_done=1: pc <= pc+1 (mod 2^ADDR_W, so 15 wraps to 0); retired += 1; -> FETCH. exec_done outside WAIT is ignored.
- HALTED: halted=1. start=1 -> pc <= 0, -> FETCH; halted clears the same edge.
- Minimum cycles per datapath instruction: FETCH, DECODE, ISSUE (ready same cycle), WAIT (done same cycle) = 4. JMP takes 2 cycles (FETCH, DECODE).
- retired saturates: at 255 it holds, no wrap.
- start is ignored in FETCH, DECODE, ISSUE and WAIT.
- Reset mid-operation (any state, including ISSUE with exec_valid=1): immediate return to reset values; the in-flight instruction is abandoned.
- JMP to its own address: infinite loop by design. No watchdog.

Test Plan:
1. Reset then start pulse, memory [0]=MOV R0,10 ({8,0,10}) -> imem_addr=0. exec_valid rises 3 cycles after start is sampled, with opcode=8, op1=0, op2=10. After exec_done, pc=1 and retired=1.
2. Program MOV, MOV, ADD, ADDI, then HALT at [4]; exec_ready tied 1; exec_done pulsed the cycle after acceptance -> four issues in order with opcodes 8,8,0,6. halted=1 with pc=4 and retired=4.
3. exec_ready held 0 for 5 cycles in ISSUE -> exec_valid stays 1 and fields stay constant. Release ready -> exactly one acceptance, with exec_valid low the next cycle.
4. [2]=JMP op1=8'hF7, [7]=HALT -> pc becomes 7 (low bits only) with no exec_valid for the JMP. Ends halted with retired=3.
5. 16 consecutive non-control instructions starting from pc=15 -> pc wraps 15->0. A retired count run past 255 sticks at 255.
6. Assert rst_n=0 asynchronously mid-ISSUE -> exec_valid, pc, retired and halted drop to 0 without waiting for a clock edge. Start after reset refetches address 0.
